// File: rtl/audio_pwm_out_if.sv
// rtl/audio_pwm_out_if.sv - sample stream interface into audio_pwm_out
//
// Purpose: groups the valid/ready sample handshake feeding the PWM output stage.
// Signals:
//   s_data  - WIDTH-bit unsigned sample, 0 = minimum level
//   s_valid - s_data is valid
//   s_ready - sink can accept a sample this cycle
// Modports: master (sample producer), slave (audio_pwm_out).

interface audio_pwm_out_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - sample FIFO plus frame-paced 1-bit PWM audio output
//
// Purpose: buffers WIDTH-bit samples in a small FIFO, pops one sample per PWM
// frame (2^WIDTH ticks, one tick every PRESCALE clocks) and drives a registered
// 1-bit PWM pin for an external RC filter. Underrun is sticky.
// Optional macro AUDIO_PWM_SD_EN: replaces the comparator with a first-order
// sigma-delta modulator; pacing, FIFO and underrun behaviour are unchanged.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   s            - sample stream (slave modport of audio_pwm_out_if)
//   underrun_clr - clears the sticky underrun flag (a new underrun wins)
//   pwm_out      - registered PWM / modulator output
//   frame_start  - one-cycle pulse aligned with a newly loaded level
//   level        - sample currently being played
//   underrun     - sticky: frame boundary with the FIFO empty
//   fifo_count   - current FIFO occupancy

module audio_pwm_out #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  audio_pwm_out_if.slave                s,
  input  logic                          underrun_clr,
  output logic                          pwm_out,
  output logic                          frame_start,
  output logic [WIDTH-1:0]              level,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             underrun_q, underrun_d;
  logic             frame_start_q, frame_start_d;
  logic             pwm_q, pwm_d;

`ifdef AUDIO_PWM_SD_EN
  // The modulator accumulator is {pwm_q, acc_q}: pwm_q holds the carry bit.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   acc_sum;
`endif

  logic tick, boundary, full, empty, push, pop;

  always_comb begin
    tick     = (presc_q == PW'(PRESCALE - 1));
    boundary = tick && (cnt_q == {WIDTH{1'b1}});
    full     = (count_q == CW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    // Ready is a function of occupancy only, never of s_valid.
    push     = s.s_valid && !full;
    // Pop decision uses the pre-push occupancy, so a push on the boundary
    // into an empty FIFO still counts as an underrun.
    pop      = boundary && !empty;
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d   = tick ? cnt_q + WIDTH'(1) : cnt_q;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s.s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (pop) begin
      level_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A fresh underrun takes priority over the clear request.
    underrun_d = underrun_q;
    if (boundary && empty) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end

    frame_start_d = boundary;

`ifdef AUDIO_PWM_SD_EN
    acc_sum = {1'b0, acc_q} + {1'b0, level_q};
    acc_d   = acc_q;
    pwm_d   = pwm_q;
    if (tick) begin
      acc_d = acc_sum[WIDTH-1:0];
      pwm_d = acc_sum[WIDTH];
    end
`else
    pwm_d = (cnt_q < level_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      level_q       <= '0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
      pwm_q         <= 1'b0;
`ifdef AUDIO_PWM_SD_EN
      acc_q         <= '0;
`endif
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      level_q       <= level_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
      pwm_q         <= pwm_d;
`ifdef AUDIO_PWM_SD_EN
      acc_q         <= acc_d;
`endif
    end
  end

  assign s.s_ready   = !full;
  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign level       = level_q;
  assign underrun    = underrun_q;
  assign fifo_count  = count_q;

endmodule
